// File: rtl/uart_receiver_fsm.sv
// rtl/uart_receiver_fsm.sv - 16x-oversampled UART receive FSM with start-bit validation and stop/frame checking
// Even-parity checking between DATA and STOP is enabled by defining UART_RX_PARITY_EN.
module uart_receiver_fsm #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic                 parity_err
);

  // tick_cnt compares (7 and 15) assume OVERSAMPLE is 16
  localparam int          DIV_RAW  = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int          DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam logic [31:0] DIV_LAST = 32'(DIV - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_d;
  logic                 rx_m, rx_s;
  logic [31:0]          div_cnt;
  logic                 tick;
  logic [3:0]           tick_cnt, tick_cnt_d;
  logic [2:0]           bit_cnt, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 valid_d, ferr_d;
  logic                 armed, armed_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_bit_d;
  logic                 perr_d;
`endif

  assign tick = (div_cnt == DIV_LAST);
  assign busy = (state != S_IDLE);

  always_comb begin
    state_d    = state;
    tick_cnt_d = tick_cnt;
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    data_d     = data_out;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    armed_d    = armed;
`ifdef UART_RX_PARITY_EN
    par_bit_d  = par_bit;
    perr_d     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        // a line stuck low after a framing error must go high before re-arming
        if (rx_s) armed_d = 1'b1;
        if (tick && armed && !rx_s) begin
          state_d    = S_START;
          tick_cnt_d = 4'd0;
        end
      end
      S_START: begin
        if (tick) begin
          if (tick_cnt == 4'd7) begin
            tick_cnt_d = 4'd0;
            bit_cnt_d  = 3'd0;
            state_d    = rx_s ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          tick_cnt_d = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            shreg_d   = {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              tick_cnt_d = 4'd0;
`ifdef UART_RX_PARITY_EN
              state_d    = S_PARITY;
`else
              state_d    = S_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          tick_cnt_d = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            par_bit_d  = rx_s;
            tick_cnt_d = 4'd0;
            state_d    = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            tick_cnt_d = 4'd0;
            state_d    = S_IDLE;
            armed_d    = rx_s;
            if (rx_s) begin
              valid_d = 1'b1;
              data_d  = shreg;
            end else begin
              ferr_d  = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            perr_d = ^{shreg, par_bit};
`endif
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        tick_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      div_cnt    <= '0;
      state      <= S_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      armed      <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      div_cnt    <= tick ? '0 : div_cnt + 32'd1;
      state      <= state_d;
      tick_cnt   <= tick_cnt_d;
      bit_cnt    <= bit_cnt_d;
      shreg      <= shreg_d;
      data_out   <= data_d;
      data_valid <= valid_d;
      frame_err  <= ferr_d;
      armed      <= armed_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bit    <= par_bit_d;
      parity_err <= perr_d;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_receiver_fsm.md
Name: uart_receiver_fsm

Overview:
UART receive path; the counterpart of the existing transmitter FSM. It samples the serial line at 16x the baud rate, derived internally from sys_clk. It detects and validates the start bit, shifts in DATA_BITS bits LSB-first, checks the stop bit, and presents the byte with a one-cycle valid strobe. It sits between the pad-side rx pin and the host-side consumer.

Parameters:
CLK_FREQ, 50_000_000, sys_clk frequency in Hz
BAUD, 115200, line rate in bits/s
DATA_BITS, 8, payload bits per frame (5..8)
OVERSAMPLE, 16, sample ticks per bit period (fixed at 16; the parameter is documentation only)

Ports:
sys_clk  in  1  system clock; the only clock
rst  in  1  reset
rx  in  1  asynchronous serial input; idles high
data_out  out  DATA_BITS  last received payload
data_valid  out  1  one-cycle strobe, payload valid
frame_err  out  1  one-cycle strobe, stop bit sampled low
busy  out  1  high from start-bit detection until return to IDLE
parity_err  out  1  one-cycle strobe; see Optional Feature

Behaviour:
- Clock and reset (already decided): one clock; reset is synchronous and active-high.
- Reset values: data_out=0, data_valid=0, frame_err=0, busy=0, parity_err=0. State=IDLE, all counters=0, synchroniser flops=1.
- Reset asserted mid-frame aborts the frame on the next edge, with no strobes.
- Input synchroniser: 2-flop synchroniser on rx, resetting to 1. All logic uses the synchronised signal rx_s, which adds 2 cycles of latency.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*16), integer truncation.
  - Counter runs 0..DIV-1 and wraps; tick is high for one cycle at wrap.
  - The counter free-runs in all states; it is not restarted on start-bit detection.
- tick_cnt (4 bits) counts ticks within a bit and is cleared on every state entry.
- States and transitions:
  - IDLE: busy=0. On rx_s==0 at a tick, go to START.
  - START: on tick, tick_cnt increments. At tick_cnt==7 (mid-bit), sample rx_s.
    - Sample 0: clear tick_cnt and bit_cnt, go to DATA.
    - Sample 1: glitch; return to IDLE with no strobes.
  - DATA: on tick, tick_cnt increments. At tick_cnt==15, sample rx_s into the shift register MSB and shift right (LSB-first).
    - bit_cnt increments.
    - When bit_cnt reaches DATA_BITS-1 and that sample is taken, go to STOP (or PARITY under the macro).
  - STOP: at tick_cnt==15, sample rx_s.
    - 1: data_out <= shift register; data_valid=1 for one cycle.
    - 0: frame_err=1 for one cycle; data_out is unchanged.
    - In both cases, go to IDLE in the same cycle the strobe asserts.
- busy is 1 in START, DATA, STOP and PARITY.
- data_valid and frame_err are never asserted together.
- A new start bit may be detected on the first tick after returning to IDLE. Back-to-back frames with no idle gap must be received.
- The consumer has no back-pressure. A new byte overwrites data_out; the strobe is the only handshake.
- rx held low continuously produces one frame_err, then the FSM re-arms. No further frames are accepted until rx_s returns high and then falls again: IDLE detects the falling level only after rx_s==1 has been seen once since the last frame.

Optional Feature:
Macro: UART_RX_PARITY_EN
- Defined:
  - A PARITY state sits between DATA and STOP.
  - At tick_cnt==15 the parity bit is sampled.
  - Even parity is checked over payload plus parity bit.
  - On mismatch, parity_err=1 for one cycle in the same cycle as data_valid/frame_err at the end of STOP. data_out is still updated if the stop bit is good.
- Not defined: no PARITY state; parity_err is tied to 0; the frame is start + DATA_BITS + stop.

Test Plan:
- Reset hold: rst=1 for 5 cycles with rx toggling -> all outputs 0, busy=0.
- Single byte: bench overrides CLK_FREQ=16*4*BAUD so DIV=4, then drives frame 0x55, LSB-first, stop=1 -> exactly one data_valid pulse, data_out=0x55, frame_err=0. Also check busy deasserts in the data_valid cycle.
- Back-to-back: frames 0xA3 then 0x0F with no idle gap -> two data_valid pulses, data_out=0xA3 then 0x0F, no frame_err.
- Framing error: byte 0xFF with stop=0 -> frame_err pulse, data_valid=0, data_out keeps its previous value. Then a valid 0x12 frame -> data_valid, 0x12.
- Start glitch: rx low for 3 ticks (less than half a bit), then high -> FSM returns to IDLE, no strobes, busy pulses then 0.
- Mid-frame reset: assert rst during DATA bit 4 of 0xC6 -> no strobes, state IDLE. The next full frame 0x3C is received correctly.
- With UART_RX_PARITY_EN defined: frame 0x07 with parity bit 0 -> data_valid with data_out=0x07 plus parity_err=1. Same frame with parity bit 1 -> parity_err=0.
